// File: rtl/pkt_buf_pkg.sv
// pkt_buf_pkg: buffer-state encoding and buffer ids shared by the packet scheduler
package pkt_buf_pkg;
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    READY   = 2'd2,
    READING = 2'd3
  } buf_st_t;
  localparam logic BUF_PING = 1'b0;
  localparam logic BUF_PONG = 1'b1;
endpackage

// File: rtl/buf_slot_fsm.sv
// buf_slot_fsm: one packet buffer's ownership state and latched packet length
module buf_slot_fsm
  import pkt_buf_pkg::*;
#(
  parameter int LEN_WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fill,
  input  logic                 fill_done,
  input  logic [LEN_WIDTH-1:0] fill_len,
  input  logic                 read,
  input  logic                 read_done,
  output buf_st_t              state,
  output logic [LEN_WIDTH-1:0] len
);
  buf_st_t state_n;
  // the arbiter only raises an event that is legal for the current state
  always_comb
    state_n = fill      ? FILLING :
              fill_done ? (fill_len != '0 ? READY : EMPTY) :
              read      ? READING :
              read_done ? EMPTY : state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      len   <= '0;
    end else begin
      state <= state_n;
      if (fill_done && fill_len != '0) len <= fill_len;
    end
  end
endmodule

// File: rtl/packet_buf_sched.sv
// packet_buf_sched: ping-pong ownership arbiter between packet snooper and BPF CPU
module packet_buf_sched
  import pkt_buf_pkg::*;
#(
  parameter int BYTE_ADDR_WIDTH = 12,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sn_req,
  output logic                   sn_grant,
  output logic                   sn_wr_sel,
  input  logic                   sn_done,
  input  logic [BYTE_ADDR_WIDTH:0] sn_len,
  input  logic                   cpu_req,
  output logic                   cpu_grant,
  output logic                   cpu_rd_sel,
  output logic [BYTE_ADDR_WIDTH:0] cpu_len,
  input  logic                   cpu_done,
  input  logic                   cpu_accept,
  output logic [3:0]             buf_state,
  output logic [CNT_WIDTH-1:0]   acc_cnt,
  output logic [CNT_WIDTH-1:0]   rej_cnt,
  output logic [CNT_WIDTH-1:0]   drop_cnt
);
  localparam int LW = BYTE_ADDR_WIDTH + 1;
  buf_st_t st [2];
  logic [LW-1:0] len [2];
  logic next_fill, rd_head;
  logic sn_ok, sn_pick, sn_fin, cpu_ok, cpu_pick, cpu_fin;
  always_comb begin
    sn_fin   = sn_done && sn_grant;
    cpu_fin  = cpu_done && cpu_grant;
    sn_ok    = sn_req && !sn_grant && (st[0] == EMPTY || st[1] == EMPTY);
    sn_pick  = st[next_fill] == EMPTY ? next_fill : ~next_fill;
    cpu_ok   = cpu_req && !cpu_grant && (st[0] == READY || st[1] == READY);
    cpu_pick = st[rd_head] == READY ? rd_head : ~rd_head;
  end
  for (genvar i = 0; i < 2; i++) begin : g_slot
    buf_slot_fsm #(.LEN_WIDTH(LW)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .fill      (sn_ok && sn_pick == 1'(i)),
      .fill_done (sn_fin && sn_wr_sel == 1'(i)),
      .fill_len  (sn_len),
      .read      (cpu_ok && cpu_pick == 1'(i)),
      .read_done (cpu_fin && cpu_rd_sel == 1'(i)),
      .state     (st[i]),
      .len       (len[i])
    );
  end
  assign buf_state = {st[BUF_PONG], st[BUF_PING]};
  always_ff @(posedge clk) begin
    if (rst) begin
      sn_grant   <= 1'b0;
      sn_wr_sel  <= 1'b0;
      cpu_grant  <= 1'b0;
      cpu_rd_sel <= 1'b0;
      cpu_len    <= '0;
      next_fill  <= 1'b0;
      rd_head    <= 1'b0;
      acc_cnt    <= '0;
      rej_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      if (sn_ok) begin
        sn_grant  <= 1'b1;
        sn_wr_sel <= sn_pick;
        next_fill <= ~next_fill;
      end else if (sn_fin) sn_grant <= 1'b0;
      if (cpu_ok) begin
        cpu_grant  <= 1'b1;
        cpu_rd_sel <= cpu_pick;
        cpu_len    <= len[cpu_pick];
      end else if (cpu_fin) cpu_grant <= 1'b0;
      // oldest-ready tracking: only a lone READY buffer becomes the read head
      if (sn_fin && sn_len != '0 && st[~sn_wr_sel] != READY) rd_head <= sn_wr_sel;
      if (sn_fin && sn_len == '0 && ~&drop_cnt) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      if (cpu_fin && cpu_accept && ~&acc_cnt) acc_cnt <= acc_cnt + CNT_WIDTH'(1);
      if (cpu_fin && !cpu_accept && ~&rej_cnt) rej_cnt <= rej_cnt + CNT_WIDTH'(1);
    end
  end
endmodule
